// File: rtl/snooper_adapter_pkg.sv
// -----------------------------------------------------------------------------
// snooper_adapter_pkg
// Shared definitions for the P3 agent adapters:
//   - mem_width(): memory word width derived from the byte/word address widths
//   - state_t:     snooper write FSM encoding
//   - keep_popcount(): number of valid bytes in a 4-bit keep field (also used
//                      by the CPU read adapter's transfer-size logic)
// -----------------------------------------------------------------------------
package snooper_adapter_pkg;

  localparam int SN_KEEP_WIDTH = 4;

  // A memory word holds 2^(byte_addr_width - addr_width) bytes.
  function automatic int mem_width(input int byte_addr_width, input int addr_width);
    return (1 << (byte_addr_width - addr_width)) * 8;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,   // waiting for the controller to offer a free buffer
    ST_LO,     // next accepted beat is the even (upper) word of a bigword
    ST_HI,     // next accepted beat is the odd (lower) word of a bigword
    ST_DRAIN,  // buffer full: consume and drop the rest of the packet
    ST_DONE    // completion handshake towards the controller
  } state_t;

  function automatic logic [2:0] keep_popcount(input logic [SN_KEEP_WIDTH-1:0] keep);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < SN_KEEP_WIDTH; i++) begin
      cnt = cnt + {2'b00, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/snooper_adapter_packer.sv
// -----------------------------------------------------------------------------
// bigword_packer
// Holds the even (lo) word of a bigword and issues the registered bigword
// write once the odd (hi) word arrives, or a half-filled flush write when a
// packet ends on an even word.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   lo_load          accepted beat is the even word (latched)
//   hi_load          accepted beat is the odd word (write issued)
//   flush            packet ended on an even word with at least one byte
//   beat_data/keep   accepted beat contents
//   wr_en/data/be    registered write strobe, bigword, byte enables
// -----------------------------------------------------------------------------
module bigword_packer #(
  parameter  int MEM_WIDTH  = 32,
  localparam int KEEP_WIDTH = MEM_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lo_load,
  input  logic                    hi_load,
  input  logic                    flush,
  input  logic [MEM_WIDTH-1:0]    beat_data,
  input  logic [KEEP_WIDTH-1:0]   beat_keep,
  output logic                    wr_en,
  output logic [2*MEM_WIDTH-1:0]  wr_data,
  output logic [2*KEEP_WIDTH-1:0] wr_be
);

  logic [MEM_WIDTH-1:0]    lo_data_reg;
  logic [KEEP_WIDTH-1:0]   lo_be_reg;
  logic                    wr_en_reg;
  logic [2*MEM_WIDTH-1:0]  wr_data_reg;
  logic [2*KEEP_WIDTH-1:0] wr_be_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_data_reg <= '0;
      lo_be_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= '0;
      wr_be_reg   <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      if (lo_load) begin
        lo_data_reg <= beat_data;
        lo_be_reg   <= beat_keep;
      end
      // A flush carries the even word straight through; the odd half is empty.
      if (flush) begin
        wr_en_reg   <= 1'b1;
        wr_data_reg <= {beat_data, {MEM_WIDTH{1'b0}}};
        wr_be_reg   <= {beat_keep, {KEEP_WIDTH{1'b0}}};
      end
      if (hi_load) begin
        wr_en_reg   <= 1'b1;
        wr_data_reg <= {lo_data_reg, beat_data};
        wr_be_reg   <= {lo_be_reg, beat_keep};
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_data = wr_data_reg;
  assign wr_be   = wr_be_reg;

endmodule

// File: rtl/snooper_adapter.sv
// -----------------------------------------------------------------------------
// snooper_adapter
// Accepts a 32-bit snooped packet stream, packs beat pairs into 64-bit
// bigwords and writes them into packet memory from pair index 0. At end of
// packet it pulses pkt_done with the stored byte length and a truncation flag.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   sn_data/keep/vld/last, sn_rdy    snooped beat stream (big-endian)
//   buf_rdy                          controller has a free buffer (IDLE only)
//   wr_en/addr/data/be               bigword write port (addr = pair index)
//   byte_len, truncated, pkt_done    completion report
// -----------------------------------------------------------------------------
module snooper_adapter
  import snooper_adapter_pkg::*;
#(
  parameter  int BYTE_ADDR_WIDTH = 12,
  parameter  int ADDR_WIDTH      = 10,
  parameter  bit BUF_IN          = 1'b0,
  localparam int MEM_WIDTH       = mem_width(BYTE_ADDR_WIDTH, ADDR_WIDTH),
  localparam int KEEP_WIDTH      = MEM_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MEM_WIDTH-1:0]     sn_data,
  input  logic [KEEP_WIDTH-1:0]    sn_keep,
  input  logic                     sn_vld,
  input  logic                     sn_last,
  output logic                     sn_rdy,
  input  logic                     buf_rdy,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-2:0]    wr_addr,
  output logic [2*MEM_WIDTH-1:0]   wr_data,
  output logic [2*KEEP_WIDTH-1:0]  wr_be,
  output logic [BYTE_ADDR_WIDTH:0] byte_len,
  output logic                     truncated,
  output logic                     pkt_done
);

  localparam logic [ADDR_WIDTH-2:0]      PAIR_MAX = '1;
  localparam logic [ADDR_WIDTH-2:0]      PAIR_ONE = 1;
  localparam logic [BYTE_ADDR_WIDTH+1:0] CAPACITY = (BYTE_ADDR_WIDTH+2)'(1) << BYTE_ADDR_WIDTH;

  state_t                   state_reg;
  logic                     sn_rdy_reg;
  logic [ADDR_WIDTH-2:0]    pair_cnt_reg;
  logic [BYTE_ADDR_WIDTH:0] byte_len_reg;
  logic                     trunc_reg;
  logic                     pkt_done_reg;
  logic                     wait_wr_reg;   // final write still in flight when DONE is entered

  logic                     port_accept;
  logic                     beat_vld;
  logic [MEM_WIDTH-1:0]     beat_data;
  logic [KEEP_WIDTH-1:0]    beat_keep;
  logic                     beat_last;

  assign port_accept = sn_vld & sn_rdy_reg;

  // Optional input stage. Only beats already accepted at the port travel
  // through it, so the handshake itself is never delayed.
  generate
    if (BUF_IN) begin : g_buf_in
      logic                  beat_vld_reg;
      logic [MEM_WIDTH-1:0]  beat_data_reg;
      logic [KEEP_WIDTH-1:0] beat_keep_reg;
      logic                  beat_last_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          beat_vld_reg  <= 1'b0;
          beat_data_reg <= '0;
          beat_keep_reg <= '0;
          beat_last_reg <= 1'b0;
        end else begin
          beat_vld_reg  <= port_accept;
          beat_data_reg <= sn_data;
          beat_keep_reg <= sn_keep;
          beat_last_reg <= sn_last;
        end
      end

      assign beat_vld  = beat_vld_reg;
      assign beat_data = beat_data_reg;
      assign beat_keep = beat_keep_reg;
      assign beat_last = beat_last_reg;
    end else begin : g_direct_in
      assign beat_vld  = port_accept;
      assign beat_data = sn_data;
      assign beat_keep = sn_keep;
      assign beat_last = sn_last;
    end
  endgenerate

  logic lo_load;
  logic hi_load;
  logic flush;
  logic store_beat;

  assign lo_load    = beat_vld && (state_reg == ST_LO);
  assign hi_load    = beat_vld && (state_reg == ST_HI);
  assign flush      = lo_load && beat_last && (beat_keep != '0);
  assign store_beat = lo_load || hi_load;

  // Saturating byte count.
  logic [BYTE_ADDR_WIDTH+1:0] len_sum;
  logic [BYTE_ADDR_WIDTH:0]   byte_len_next;

  always_comb begin
    len_sum       = {1'b0, byte_len_reg} + {{(BYTE_ADDR_WIDTH-1){1'b0}}, keep_popcount(beat_keep)};
    byte_len_next = len_sum[BYTE_ADDR_WIDTH:0];
    if (len_sum > CAPACITY) begin
      byte_len_next = CAPACITY[BYTE_ADDR_WIDTH:0];
    end
  end

  bigword_packer #(
    .MEM_WIDTH (MEM_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .lo_load   (lo_load),
    .hi_load   (hi_load),
    .flush     (flush),
    .beat_data (beat_data),
    .beat_keep (beat_keep),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_be     (wr_be)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      sn_rdy_reg   <= 1'b0;
      pair_cnt_reg <= '0;
      byte_len_reg <= '0;
      trunc_reg    <= 1'b0;
      pkt_done_reg <= 1'b0;
      wait_wr_reg  <= 1'b0;
    end else begin
      pkt_done_reg <= 1'b0;

      // The pair index follows the registered write, so it always names the
      // pair being written while wr_en is high. It stops at the last pair.
      if (wr_en && (pair_cnt_reg != PAIR_MAX)) begin
        pair_cnt_reg <= pair_cnt_reg + PAIR_ONE;
      end
      if (store_beat) begin
        byte_len_reg <= byte_len_next;
      end

      // Stop accepting as soon as a last beat is taken at the port; with the
      // input stage the FSM only sees that beat one cycle later.
      if (port_accept && sn_last) begin
        sn_rdy_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (buf_rdy) begin
            state_reg    <= ST_LO;
            sn_rdy_reg   <= 1'b1;
            pair_cnt_reg <= '0;
            byte_len_reg <= '0;
            trunc_reg    <= 1'b0;
          end
        end
        ST_LO: begin
          if (beat_vld) begin
            if (beat_last) begin
              state_reg   <= ST_DONE;
              sn_rdy_reg  <= 1'b0;
              wait_wr_reg <= (beat_keep != '0);
              // Nothing to write: report completion right away.
              if (beat_keep == '0) begin
                pkt_done_reg <= 1'b1;
              end
            end else begin
              state_reg <= ST_HI;
            end
          end
        end
        ST_HI: begin
          if (beat_vld) begin
            if (beat_last) begin
              state_reg   <= ST_DONE;
              sn_rdy_reg  <= 1'b0;
              wait_wr_reg <= 1'b1;
            end else if (pair_cnt_reg == PAIR_MAX) begin
              state_reg <= ST_DRAIN;
              trunc_reg <= 1'b1;
            end else begin
              state_reg <= ST_LO;
            end
          end
        end
        ST_DRAIN: begin
          if (beat_vld && beat_last) begin
            state_reg    <= ST_DONE;
            sn_rdy_reg   <= 1'b0;
            pkt_done_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          // The final write lands this cycle; completion follows it.
          pkt_done_reg <= wait_wr_reg;
          wait_wr_reg  <= 1'b0;
          sn_rdy_reg   <= 1'b0;
          state_reg    <= ST_IDLE;
        end
        default: begin
          state_reg  <= ST_IDLE;
          sn_rdy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign sn_rdy    = sn_rdy_reg;
  assign wr_addr   = pair_cnt_reg;
  assign byte_len  = byte_len_reg;
  assign truncated = trunc_reg;
  assign pkt_done  = pkt_done_reg;

endmodule

// File: tb/tb_snooper_adapter.sv
module tb_snooper_adapter;

  localparam int BAW = 12;
  localparam int AW  = 10;
  localparam int CAP = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sn_data = '0;
  logic [3:0]  sn_keep = '0;
  logic        sn_vld = 1'b0;
  logic        sn_last = 1'b0;
  logic        sn_rdy;
  logic        buf_rdy = 1'b0;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic [12:0] byte_len;
  logic        truncated;
  logic        pkt_done;

  always #5 clk = ~clk;

  snooper_adapter #(
    .BYTE_ADDR_WIDTH (BAW),
    .ADDR_WIDTH      (AW),
    .BUF_IN          (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sn_data   (sn_data),
    .sn_keep   (sn_keep),
    .sn_vld    (sn_vld),
    .sn_last   (sn_last),
    .sn_rdy    (sn_rdy),
    .buf_rdy   (buf_rdy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .byte_len  (byte_len),
    .truncated (truncated),
    .pkt_done  (pkt_done)
  );

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [8:0]  addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_exp_t;
  typedef struct {
    logic [12:0] len;
    logic        trunc;
    bit          timed;   // completion must follow the final write by one cycle
  } done_exp_t;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = -10;
  bit abort = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: the packet is a byte string; the memory image is that
  // string cut at the buffer capacity and grouped eight bytes per pair.
  task automatic model_packet(input byte_q_t b);
    int n;
    int stored;
    wr_exp_t e;
    done_exp_t d;
    n = b.size();
    stored = (n > CAP) ? CAP : n;
    for (int w = 0; w < (stored + 7) / 8; w++) begin
      e.addr = 9'(w);
      e.data = '0;
      e.be   = '0;
      for (int j = 0; j < 8; j++) begin
        if (8 * w + j < stored) begin
          e.data[63 - 8*j -: 8] = b[8*w + j];
          e.be[7 - j] = 1'b1;
        end
      end
      wr_q.push_back(e);
    end
    d.len   = 13'(stored);
    d.trunc = (n > CAP);
    d.timed = (stored > 0) && (n <= CAP);
    done_q.push_back(d);
  endtask

  // Presents one beat from a negedge and returns at the negedge after it
  // was accepted (sn_rdy is registered, so its value here holds to the edge).
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int waited;
    waited = 0;
    sn_data = d;
    sn_keep = k;
    sn_last = l;
    sn_vld  = 1'b1;
    while (sn_rdy !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        checks++;
        errors++;
        $display("FAIL sn_rdy_timeout: sn_rdy=%b after %0d cycles, required 1", sn_rdy, waited);
        abort  = 1'b1;
        sn_vld = 1'b0;
        return;
      end
    end
    @(negedge clk);
    sn_vld = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
    end
  endtask

  task automatic send_packet(input byte_q_t b);
    int n;
    int nb;
    logic [31:0] d;
    logic [3:0]  k;
    n  = b.size();
    nb = (n == 0) ? 1 : (n + 3) / 4;
    model_packet(b);
    buf_rdy = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    buf_rdy = 1'b1;
    for (int i = 0; i < nb && !abort; i++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * i + j < n) begin
          d[31 - 8*j -: 8] = b[4*i + j];
          k[3 - j] = 1'b1;
        end
      end
      drive_beat(d, k, (i == nb - 1));
      // Ignored outside IDLE; wiggle it to show that.
      buf_rdy = 1'($urandom_range(0, 1));
    end
    sn_vld = 1'b0;
  endtask

  task automatic rand_bytes(input int n, output byte_q_t b);
    b = {};
    for (int i = 0; i < n; i++) begin
      b.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (sn_rdy !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 9'd0 || wr_data !== 64'd0 ||
        wr_be !== 8'd0 || byte_len !== 13'd0 || truncated !== 1'b0 || pkt_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: sn_rdy=%b wr_en=%b wr_addr=%0d wr_data=%h wr_be=%h byte_len=%0d truncated=%b pkt_done=%b, required all 0",
               name, sn_rdy, wr_en, wr_addr, wr_data, wr_be, byte_len, truncated, pkt_done);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a
  // completion.
  wr_exp_t   mon_w;
  done_exp_t mon_d;

  initial forever begin
    @(negedge clk);
    if (rst === 1'b1) begin
      if (wr_en === 1'b1) begin
        checks++;
        $display("write addr=%0d data=%h be=%h", wr_addr, wr_data, wr_be);
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: addr=%0d data=%h be=%h, required no write", wr_addr, wr_data, wr_be);
        end else begin
          mon_w = wr_q.pop_front();
          if (wr_addr !== mon_w.addr || wr_data !== mon_w.data || wr_be !== mon_w.be) begin
            errors++;
            $display("FAIL wr_beat: addr=%0d data=%h be=%h, required addr=%0d data=%h be=%h",
                     wr_addr, wr_data, wr_be, mon_w.addr, mon_w.data, mon_w.be);
          end
        end
        last_wr_cyc = cyc;
      end
      if (pkt_done === 1'b1) begin
        checks++;
        $display("done byte_len=%0d truncated=%b", byte_len, truncated);
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: byte_len=%0d truncated=%b, required no pkt_done", byte_len, truncated);
        end else begin
          mon_d = done_q.pop_front();
          if (byte_len !== mon_d.len || truncated !== mon_d.trunc) begin
            errors++;
            $display("FAIL done_report: byte_len=%0d truncated=%b, required byte_len=%0d truncated=%b",
                     byte_len, truncated, mon_d.len, mon_d.trunc);
          end
          if (mon_d.timed && cyc != last_wr_cyc + 1) begin
            errors++;
            $display("FAIL done_latency: pkt_done %0d cycles after last write, required 1", cyc - last_wr_cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: time limit reached with %0d writes and %0d completions pending, required 0",
             wr_q.size(), done_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  byte_q_t pkt;
  wr_exp_t rw;
  int wait_cnt;

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_values");
    rst = 1'b1;

    // No buffer offered: stream stays stalled.
    sn_data = 32'h01020304;
    sn_keep = 4'hF;
    sn_last = 1'b0;
    sn_vld  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (sn_rdy !== 1'b0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL buf_rdy_gate: sn_rdy=%b wr_en=%b in cycle %0d, required 0/0", sn_rdy, wr_en, i);
      end
    end
    sn_vld  = 1'b0;
    buf_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (sn_rdy !== 1'b1) begin
      errors++;
      $display("FAIL buf_rdy_rise: sn_rdy=%b one cycle after buf_rdy, required 1", sn_rdy);
    end

    // Directed packets.
    pkt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_packet(pkt);
    pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_packet(pkt);
    pkt = {8'h11, 8'h22, 8'h33};
    send_packet(pkt);
    pkt = {};
    send_packet(pkt);

    // Random packets, including empty and one-byte ones.
    for (int p = 0; p < 40 && !abort; p++) begin
      rand_bytes($urandom_range(0, 40), pkt);
      send_packet(pkt);
    end

    // Reset in the middle of a 16-byte packet, after its third beat.
    if (!abort) begin
      rand_bytes(16, pkt);
      rw.addr = 9'd0;
      rw.data = {pkt[0], pkt[1], pkt[2], pkt[3], pkt[4], pkt[5], pkt[6], pkt[7]};
      rw.be   = 8'hFF;
      wr_q.push_back(rw);
      buf_rdy = 1'b1;
      for (int i = 0; i < 3 && !abort; i++) begin
        drive_beat({pkt[4*i], pkt[4*i+1], pkt[4*i+2], pkt[4*i+3]}, 4'hF, 1'b0);
      end
      sn_vld = 1'b0;
      #1 rst = 1'b0;
      #1 check_zero("mid_packet_reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      rand_bytes(16, pkt);
      send_packet(pkt);
    end

    // Capacity boundaries: exactly full, and overflow with one drained beat.
    if (!abort) begin
      rand_bytes(CAP, pkt);
      send_packet(pkt);
    end
    if (!abort) begin
      rand_bytes(CAP + 4, pkt);
      send_packet(pkt);
    end
    if (!abort) begin
      rand_bytes(9, pkt);
      send_packet(pkt);
    end

    wait_cnt = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d writes and %0d completions outstanding, required 0/0",
               wr_q.size(), done_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
